pac_voice_allocator: RTL and testbench

- Polyphony scheduler that shares a fixed pool of NUM_VOICES phase accumulators (PACs) between incoming key events.
- Accepts key-on/key-off events over a valid/ready handshake and looks up the step frequency and divider from an external synchronous key ROM.
- Chooses a voice (retrigger, free, or steal-oldest) and emits one configuration write that loads f/pac_max into that voice's PAC or silences it.
- Sits between the keyboard scanner and the PAC bank, replacing fixed per-key PAC instances.

---
 rtl/pac_voice_allocator_if.sv | 37 +++
 rtl/pac_voice_allocator.sv | 173 +++++++++++++++++
 tb/tb_pac_voice_allocator.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pac_voice_allocator_if.sv
// Key-event, key-ROM and PAC-configuration signals shared by the keyboard side,
// the key ROM and the voice allocator.
interface pac_voice_allocator_if #(
  parameter int NUM_VOICES    = 4,
  parameter int KEY_WIDTH     = 7,
  parameter int F_WIDTH       = 8,
  parameter int PAC_MAX_WIDTH = 16
) ();
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                     key_valid;
  logic                     key_ready;
  logic                     key_on;
  logic [KEY_WIDTH-1:0]     key_num;
  logic [KEY_WIDTH-1:0]     lut_key;
  logic [F_WIDTH-1:0]       lut_f;
  logic [PAC_MAX_WIDTH-1:0] lut_pac_max;
  logic                     cfg_valid;
  logic [VW-1:0]            cfg_voice;
  logic                     cfg_enable;
  logic [F_WIDTH-1:0]       cfg_f;
  logic [PAC_MAX_WIDTH-1:0] cfg_pac_max;
  logic [NUM_VOICES-1:0]    voice_active;
  logic                     err;

  modport master (
    output key_valid, key_on, key_num, lut_f, lut_pac_max,
    input  key_ready, lut_key, cfg_valid, cfg_voice, cfg_enable, cfg_f,
           cfg_pac_max, voice_active, err
  );

  modport slave (
    input  key_valid, key_on, key_num, lut_f, lut_pac_max,
    output key_ready, lut_key, cfg_valid, cfg_voice, cfg_enable, cfg_f,
           cfg_pac_max, voice_active, err
  );
endinterface

// File: rtl/pac_voice_allocator.sv
// Polyphony scheduler: maps key events onto a shared pool of PAC voices
// (retrigger, lowest free, or steal oldest) and emits one config write per event.
module pac_voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int KEY_WIDTH     = 7,
  parameter int F_WIDTH       = 8,
  parameter int PAC_MAX_WIDTH = 16,
  parameter int AGE_WIDTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  pac_voice_allocator_if.slave bus
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_SELECT, S_WRITE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_key_ready;
  logic                     w_accept;

  logic                     r_key_on;
  logic [KEY_WIDTH-1:0]     r_key;
  logic                     r_cfg_valid;
  logic [VW-1:0]            r_cfg_voice;
  logic                     r_cfg_enable;
  logic [F_WIDTH-1:0]       r_cfg_f;
  logic [PAC_MAX_WIDTH-1:0] r_cfg_pac_max;
  logic                     r_err;

  logic [NUM_VOICES-1:0]    r_active;
  logic [KEY_WIDTH-1:0]     r_vkey [NUM_VOICES];
  logic [AGE_WIDTH-1:0]     r_age  [NUM_VOICES];

  logic [NUM_VOICES-1:0]    w_match;
  logic                     w_hit;
  logic [VW-1:0]            w_hit_idx;
  logic                     w_free_any;
  logic [VW-1:0]            w_free_idx;
  logic [VW-1:0]            w_old_idx;
  logic [AGE_WIDTH-1:0]     w_old_age;
  logic [VW-1:0]            w_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_key_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_key_ready = 1'b1;
        if (bus.key_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: w_next = S_SELECT;
      S_SELECT: w_next = S_WRITE;
      S_WRITE:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_accept = bus.key_valid & w_key_ready;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++)
      w_match[i] = r_active[i] && (r_vkey[i] == r_key);
  end

  // Descending scan so the lowest matching / free index is the one left standing.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = VW'(i);
      end
      if (!r_active[i]) begin
        w_free_any = 1'b1;
        w_free_idx = VW'(i);
      end
    end
  end

  // Strictly-greater compare keeps the lowest index on age ties.
  always_comb begin
    w_old_idx = '0;
    w_old_age = r_age[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = VW'(i);
      end
    end
  end

  always_comb begin
    if (w_hit)           w_target = w_hit_idx;
    else if (w_free_any) w_target = w_free_idx;
    else                 w_target = w_old_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_on      <= 1'b0;
      r_key         <= '0;
      r_cfg_valid   <= 1'b0;
      r_cfg_voice   <= '0;
      r_cfg_enable  <= 1'b0;
      r_cfg_f       <= '0;
      r_cfg_pac_max <= '0;
      r_err         <= 1'b0;
      r_active      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vkey[i] <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      r_cfg_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) begin
        r_key_on <= bus.key_on;
        r_key    <= bus.key_num;
      end
      if (r_state == S_SELECT) begin
        if (r_key_on) begin
          if (bus.lut_f == '0) begin
            r_err <= 1'b1;
          end else begin
            r_cfg_valid         <= 1'b1;
            r_cfg_voice         <= w_target;
            r_cfg_enable        <= 1'b1;
            r_cfg_f             <= bus.lut_f;
            r_cfg_pac_max       <= bus.lut_pac_max;
            r_active[w_target]  <= 1'b1;
            r_vkey[w_target]    <= r_key;
            // A retrigger only refreshes its own age; new allocations age everyone else.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (VW'(i) == w_target)
                r_age[i] <= '0;
              else if (!w_hit && r_active[i] && (r_age[i] != AGE_MAX))
                r_age[i] <= r_age[i] + AGE_WIDTH'(1);
            end
          end
        end else if (w_hit) begin
          r_cfg_valid          <= 1'b1;
          r_cfg_voice          <= w_hit_idx;
          r_cfg_enable         <= 1'b0;
          r_cfg_f              <= '0;
          r_cfg_pac_max        <= '0;
          r_active[w_hit_idx]  <= 1'b0;
          r_age[w_hit_idx]     <= '0;
        end
      end
    end
  end

  assign bus.key_ready    = w_key_ready;
  assign bus.lut_key      = r_key;
  assign bus.cfg_valid    = r_cfg_valid;
  assign bus.cfg_voice    = r_cfg_voice;
  assign bus.cfg_enable   = r_cfg_enable;
  assign bus.cfg_f        = r_cfg_f;
  assign bus.cfg_pac_max  = r_cfg_pac_max;
  assign bus.voice_active = r_active;
  assign bus.err          = r_err;
endmodule

// File: tb/tb_pac_voice_allocator.sv
// Scoreboard bench for pac_voice_allocator: directed key events, expected config
// writes queued at issue time and checked by an independent output monitor.
module tb_pac_voice_allocator;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  pac_voice_allocator_if #(.NUM_VOICES(4), .KEY_WIDTH(7), .F_WIDTH(8), .PAC_MAX_WIDTH(16)) bus ();

  pac_voice_allocator #(
    .NUM_VOICES(4), .KEY_WIDTH(7), .F_WIDTH(8), .PAC_MAX_WIDTH(16), .AGE_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous key ROM: data one cycle after the address.
  always @(posedge clk) begin
    case (bus.lut_key)
      7'd40:   begin bus.lut_f <= 8'd46; bus.lut_pac_max <= 16'h0100; end
      7'd44:   begin bus.lut_f <= 8'd52; bus.lut_pac_max <= 16'h0140; end
      7'd10:   begin bus.lut_f <= 8'd0;  bus.lut_pac_max <= 16'h0000; end
      default: begin bus.lut_f <= 8'(bus.lut_key); bus.lut_pac_max <= 16'h0200 + 16'(bus.lut_key); end
    endcase
  end

  typedef struct {
    int          cyc;
    logic [1:0]  voice;
    logic        en;
    logic [7:0]  f;
    logic [15:0] pm;
    logic        err;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    if (!rst && (bus.cfg_valid || bus.err)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: cyc=%0d cfg_valid=%0b err=%0b voice=%0d required none",
                 cyc, bus.cfg_valid, bus.err, bus.cfg_voice);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cyc != e.cyc || bus.err != e.err || bus.cfg_valid != !e.err ||
            (!e.err && (bus.cfg_voice != e.voice || bus.cfg_enable != e.en ||
                        bus.cfg_f != e.f || bus.cfg_pac_max != e.pm))) begin
          n_fail++;
          $display("FAIL cfg_write: got cyc=%0d vld=%0b err=%0b v=%0d en=%0b f=%0d pm=%h required cyc=%0d err=%0b v=%0d en=%0b f=%0d pm=%h",
                   cyc, bus.cfg_valid, bus.err, bus.cfg_voice, bus.cfg_enable, bus.cfg_f,
                   bus.cfg_pac_max, e.cyc, e.err, e.voice, e.en, e.f, e.pm);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Issue one event; when exp_out is set, the expected write/err is queued for E0+2.
  task automatic send(input logic on, input logic [6:0] k, input logic exp_out,
                      input logic [1:0] v, input logic en, input logic [7:0] f,
                      input logic [15:0] pm, input logic er);
    exp_t e;
    @(negedge clk);
    check("ready_before", bus.key_ready, 1);
    bus.key_on = on; bus.key_num = k; bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    if (exp_out) begin
      e.cyc = cyc + 2; e.voice = v; e.en = en; e.f = f; e.pm = pm; e.err = er;
      q.push_back(e);
    end
    repeat (3) begin
      @(negedge clk);
      check("ready_busy", bus.key_ready, 0);
    end
    @(negedge clk);
    check("ready_after", bus.key_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.key_valid = 1'b0; bus.key_on = 1'b0; bus.key_num = '0;
    repeat (3) @(negedge clk);
    check("rst_active", bus.voice_active, 0);
    check("rst_cfg_valid", bus.cfg_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_cfg_f", bus.cfg_f, 0);
    check("rst_lut_key", bus.lut_key, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.key_ready, 1);

    send(1, 7'd40, 1, 2'd0, 1, 8'd46, 16'h0100, 0);
    check("va_first", bus.voice_active, 4'b0001);
    send(1, 7'd41, 1, 2'd1, 1, 8'd41, 16'h0229, 0);
    send(1, 7'd42, 1, 2'd2, 1, 8'd42, 16'h022A, 0);
    send(1, 7'd43, 1, 2'd3, 1, 8'd43, 16'h022B, 0);
    check("va_full", bus.voice_active, 4'b1111);
    send(1, 7'd44, 1, 2'd0, 1, 8'd52, 16'h0140, 0);
    check("va_steal", bus.voice_active, 4'b1111);

    send(1, 7'd41, 1, 2'd1, 1, 8'd41, 16'h0229, 0);
    check("va_retrig", bus.voice_active, 4'b1111);

    send(0, 7'd60, 0, 2'd0, 0, 8'd0, 16'h0000, 0);
    check("va_off_miss", bus.voice_active, 4'b1111);
    send(0, 7'd42, 1, 2'd2, 0, 8'd0, 16'h0000, 0);
    check("va_off_hit", bus.voice_active, 4'b1011);

    send(1, 7'd10, 1, 2'd0, 0, 8'd0, 16'h0000, 1);
    check("va_drop", bus.voice_active, 4'b1011);

    send(1, 7'd45, 1, 2'd2, 1, 8'd45, 16'h022D, 0);
    send(1, 7'd46, 1, 2'd3, 1, 8'd46, 16'h022E, 0);
    send(1, 7'd47, 1, 2'd0, 1, 8'd47, 16'h022F, 0);
    check("va_after_steals", bus.voice_active, 4'b1111);

    // Abort an event by resetting while it sits in SELECT.
    @(negedge clk);
    bus.key_on = 1'b1; bus.key_num = 7'd50; bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_va_async", bus.voice_active, 0);
    check("abort_ready_async", bus.key_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.key_ready, 1);
    check("abort_va", bus.voice_active, 0);
    send(1, 7'd51, 1, 2'd0, 1, 8'd51, 16'h0233, 0);
    check("va_post_abort", bus.voice_active, 4'b0001);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
